// File: rtl/maze_pkg.sv
// -----------------------------------------------------------------------------
// maze_pkg
// Shared definitions for the maze move-legality logic:
//   - maze memory cell codes
//   - controller FSM state encoding
//   - bit positions inside the one-hot move direction {down,up,right,left}
//   - idx_width(): width of an encoded index over n items (at least 1 bit)
// -----------------------------------------------------------------------------
package maze_pkg;

  localparam int CELL_OCCUPIED  = 0;
  localparam int CELL_AVAILABLE = 1;
  localparam int CELL_START     = 2;
  localparam int CELL_END       = 3;

  localparam int DIR_LEFT  = 0;
  localparam int DIR_RIGHT = 1;
  localparam int DIR_UP    = 2;
  localparam int DIR_DOWN  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_MEM_WAIT,
    ST_DECIDE,
    ST_ACCEPT,
    ST_REJECT,
    ST_WON,
    ST_GAME_OVER
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tile_match.sv
// -----------------------------------------------------------------------------
// tile_match
// Finds the lowest-index unconsumed tile whose coordinate equals (x, y).
// Purely combinational.
// Ports:
//   xy_list  : N packed {y,x} coordinates, tile i at bits [i*2*COORD_W +: 2*COORD_W]
//   consumed : per-tile consumed mask; consumed tiles never match
//   x, y     : coordinate under test
//   hit      : some unconsumed tile matches
//   onehot   : one-hot of the winning tile (all zero when no hit)
//   idx      : encoded index of the winning tile (zero when no hit)
// -----------------------------------------------------------------------------
module tile_match
  import maze_pkg::*;
#(
  parameter  int N       = 4,
  parameter  int COORD_W = 5,
  localparam int IDX_W   = idx_width(N)
) (
  input  logic [N*2*COORD_W-1:0] xy_list,
  input  logic [N-1:0]           consumed,
  input  logic [COORD_W-1:0]     x,
  input  logic [COORD_W-1:0]     y,
  output logic                   hit,
  output logic [N-1:0]           onehot,
  output logic [IDX_W-1:0]       idx
);

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves a
    // value unassigned and no latch is inferred.
    hit    = 1'b0;
    onehot = '0;
    idx    = '0;
    // Ascending scan; the !hit guard makes the lowest index win.
    for (int i = 0; i < N; i++) begin
      if (!hit && !consumed[i] &&
          xy_list[i*2*COORD_W +: COORD_W] == x &&
          xy_list[i*2*COORD_W + COORD_W +: COORD_W] == y) begin
        hit       = 1'b1;
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/move_legality_checker.sv
// -----------------------------------------------------------------------------
// move_legality_checker
// Decides whether a proposed maze position is a legal move. It checks grid
// bounds, fetches the cell code from maze RAM over a valid handshake, resolves
// single-use bonus/penalty tiles and emits one registered result pulse.
// Ports:
//   clock, resetn       : clock, asynchronous active-low reset
//   new_game            : synchronous clear of game state, highest priority
//   check_req, x, y     : 1-cycle request with the proposed position
//   move_dir            : one-hot {down,up,right,left} that produced x,y
//   external_abort,
//   no_more_moves,
//   no_more_time        : game-over causes, sampled while checking
//   bonus_xy/penalty_xy : packed {y,x} per bonus / penalty tile
//   mem_rd_req/_x/_y    : 1-cycle read strobe and address to maze RAM
//   mem_rd_valid/_data  : read response, arbitrary latency
//   done_check          : 1-cycle result pulse; is_legal qualified by it
//   score_plus/minus    : tile pulses coincident with done_check
//   tile_idx            : index of the tile hit, valid with the pulse
//   game_won/game_over  : levels held until new_game
// -----------------------------------------------------------------------------
module move_legality_checker
  import maze_pkg::*;
#(
  parameter  int COORD_W     = 5,
  parameter  int GRID_W      = 24,
  parameter  int GRID_H      = 24,
  parameter  int CELL_W      = 3,
  parameter  int NUM_BONUS   = 4,
  parameter  int NUM_PENALTY = 4,
  localparam int TILE_IDX_W  = idx_width((NUM_BONUS > NUM_PENALTY) ? NUM_BONUS : NUM_PENALTY)
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic                           new_game,
  input  logic                           check_req,
  input  logic [COORD_W-1:0]             x,
  input  logic [COORD_W-1:0]             y,
  input  logic [3:0]                     move_dir,
  input  logic                           external_abort,
  input  logic                           no_more_moves,
  input  logic                           no_more_time,
  input  logic [NUM_BONUS*2*COORD_W-1:0]   bonus_xy,
  input  logic [NUM_PENALTY*2*COORD_W-1:0] penalty_xy,
  output logic                           mem_rd_req,
  output logic [COORD_W-1:0]             mem_rd_x,
  output logic [COORD_W-1:0]             mem_rd_y,
  input  logic                           mem_rd_valid,
  input  logic [CELL_W-1:0]              mem_rd_data,
  output logic                           done_check,
  output logic                           is_legal,
  output logic                           score_plus,
  output logic                           score_minus,
  output logic [TILE_IDX_W-1:0]          tile_idx,
  output logic                           game_won,
  output logic                           game_over
);

  localparam int B_IDX_W = idx_width(NUM_BONUS);
  localparam int P_IDX_W = idx_width(NUM_PENALTY);

  state_e                  state_q;
  logic [COORD_W-1:0]      x_q, y_q;
  logic [3:0]              dir_q;
  logic [CELL_W-1:0]       cell_q;
  logic [NUM_BONUS-1:0]    bonus_used_q;
  logic [NUM_PENALTY-1:0]  penalty_used_q;
  logic                    req_q, done_q, legal_q, plus_q, minus_q, won_q, over_q;
  logic [TILE_IDX_W-1:0]   idx_q;

  logic                    b_hit, p_hit;
  logic [NUM_BONUS-1:0]    b_onehot;
  logic [NUM_PENALTY-1:0]  p_onehot;
  logic [B_IDX_W-1:0]      b_idx;
  logic [P_IDX_W-1:0]      p_idx;

  tile_match #(.N(NUM_BONUS), .COORD_W(COORD_W)) u_bonus_match (
    .xy_list  (bonus_xy),
    .consumed (bonus_used_q),
    .x        (x_q),
    .y        (y_q),
    .hit      (b_hit),
    .onehot   (b_onehot),
    .idx      (b_idx)
  );

  tile_match #(.N(NUM_PENALTY), .COORD_W(COORD_W)) u_penalty_match (
    .xy_list  (penalty_xy),
    .consumed (penalty_used_q),
    .x        (x_q),
    .y        (y_q),
    .hit      (p_hit),
    .onehot   (p_onehot),
    .idx      (p_idx)
  );

  logic abort_any;
  logic boundary_hit;

  assign abort_any = external_abort | no_more_moves | no_more_time;

  // Edge moves that would step off the grid, plus any position already
  // outside it. Coordinates are widened so GRID_W == 2**COORD_W still works.
  assign boundary_hit = (dir_q[DIR_LEFT]  && x_q == '0)                 ||
                        (dir_q[DIR_RIGHT] && 32'(x_q) == GRID_W - 1)    ||
                        (dir_q[DIR_UP]    && y_q == '0)                 ||
                        (dir_q[DIR_DOWN]  && 32'(y_q) == GRID_H - 1)    ||
                        (32'(x_q) >= GRID_W) || (32'(y_q) >= GRID_H);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      // NOTE: every register is reset, consumed masks included, so an aborted
      // transaction leaves nothing behind and no pulse follows release.
      state_q        <= ST_IDLE;
      x_q            <= '0;
      y_q            <= '0;
      dir_q          <= '0;
      cell_q         <= '0;
      bonus_used_q   <= '0;
      penalty_used_q <= '0;
      req_q          <= 1'b0;
      done_q         <= 1'b0;
      legal_q        <= 1'b0;
      plus_q         <= 1'b0;
      minus_q        <= 1'b0;
      idx_q          <= '0;
      won_q          <= 1'b0;
      over_q         <= 1'b0;
    end else begin
      // Pulse outputs drop unless the branch below raises them.
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      legal_q <= 1'b0;
      plus_q  <= 1'b0;
      minus_q <= 1'b0;
      idx_q   <= '0;

      if (new_game) begin
        state_q        <= ST_IDLE;
        bonus_used_q   <= '0;
        penalty_used_q <= '0;
        won_q          <= 1'b0;
        over_q         <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (check_req) begin
              x_q     <= x;
              y_q     <= y;
              dir_q   <= move_dir;
              state_q <= ST_CHECK;
            end
          end

          ST_CHECK: begin
            if (abort_any) begin
              done_q  <= 1'b1;
              over_q  <= 1'b1;
              state_q <= ST_GAME_OVER;
            end else if (boundary_hit) begin
              done_q  <= 1'b1;
              state_q <= ST_REJECT;
            end else begin
              req_q   <= 1'b1;
              state_q <= ST_MEM_WAIT;
            end
          end

          ST_MEM_WAIT: begin
            if (mem_rd_valid) begin
              cell_q  <= mem_rd_data;
              state_q <= ST_DECIDE;
            end
          end

          ST_DECIDE: begin
            done_q <= 1'b1;
            // A tile hit makes the move legal whatever the cell code says.
            if (b_hit) begin
              bonus_used_q <= bonus_used_q | b_onehot;
              plus_q       <= 1'b1;
              idx_q        <= TILE_IDX_W'(b_idx);
              legal_q      <= 1'b1;
              state_q      <= ST_ACCEPT;
            end else if (p_hit) begin
              penalty_used_q <= penalty_used_q | p_onehot;
              minus_q        <= 1'b1;
              idx_q          <= TILE_IDX_W'(p_idx);
              legal_q        <= 1'b1;
              state_q        <= ST_ACCEPT;
            end else if (cell_q == CELL_W'(CELL_OCCUPIED)) begin
              state_q <= ST_REJECT;
            end else if (cell_q == CELL_W'(CELL_END)) begin
              legal_q <= 1'b1;
              won_q   <= 1'b1;
              state_q <= ST_WON;
            end else begin
              legal_q <= 1'b1;
              state_q <= ST_ACCEPT;
            end
          end

          // The result pulse was registered on entry; just return.
          ST_ACCEPT, ST_REJECT: state_q <= ST_IDLE;

          // Terminal until new_game.
          ST_WON, ST_GAME_OVER: state_q <= state_q;

          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign mem_rd_req  = req_q;
  assign mem_rd_x    = x_q;
  assign mem_rd_y    = y_q;
  assign done_check  = done_q;
  assign is_legal    = legal_q;
  assign score_plus  = plus_q;
  assign score_minus = minus_q;
  assign tile_idx    = idx_q;
  assign game_won    = won_q;
  assign game_over   = over_q;

endmodule

// File: doc/move_legality_checker.md
Name: move_legality_checker

Overview:
- Parametrised successor to the maze move-legality controller.
- After the position updater proposes a new cell, it:
  - requests that cell's contents from maze memory over a valid handshake;
  - checks grid bounds;
  - resolves NUM_BONUS single-use bonus tiles and NUM_PENALTY single-use penalty tiles;
  - issues one result pulse to the position and score datapaths.
- Sits between the position updater, the maze RAM read port and the score/timer logic.

Parameters:
- COORD_W, 5, width of x/y coordinates.
- GRID_W, 24, grid columns; legal x is 0..GRID_W-1.
- GRID_H, 24, grid rows; legal y is 0..GRID_H-1.
- CELL_W, 3, width of a maze memory cell code.
- NUM_BONUS, 4, number of bonus tiles (≥1).
- NUM_PENALTY, 4, number of penalty tiles (≥1).

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- new_game  in  1  synchronous clear of game state; also returns the FSM from WON/GAME_OVER to IDLE
- check_req  in  1  1-cycle pulse: proposed position valid (doneChangePosition)
- x, y  in  COORD_W each  proposed position
- move_dir  in  4  one-hot {down,up,right,left} that produced x,y
- external_abort, no_more_moves, no_more_time  in  1 each  game-over causes
- bonus_xy  in  NUM_BONUS*2*COORD_W  packed {y,x} per bonus tile
- penalty_xy  in  NUM_PENALTY*2*COORD_W  packed {y,x} per penalty tile
- mem_rd_req  out  1  read strobe to maze RAM
- mem_rd_x, mem_rd_y  out  COORD_W each  read address
- mem_rd_valid  in  1  mem_rd_data valid
- mem_rd_data  in  CELL_W  cell code
- done_check  out  1  1-cycle result pulse
- is_legal  out  1  qualified by done_check
- score_plus, score_minus  out  1 each  1-cycle pulses coincident with done_check
- tile_idx  out  clog2(max(NUM_BONUS,NUM_PENALTY))  index of tile hit
- game_won, game_over  out  1 each  level, held until new_game

Behaviour:
- Reset values: all outputs 0; state IDLE; bonus/penalty consumed masks all 0.
- All outputs are registered.
- Cell codes: OCCUPIED=0, AVAILABLE=1, START=2, END=3.

State IDLE:
- On check_req, latch x, y, move_dir and go to CHECK.
- check_req in any other state is ignored.

State CHECK (priority order, first match wins):
1. external_abort | no_more_moves | no_more_time → GAME_OVER.
2. Boundary hit → REJECT. Boundary hit means any of:
   - left with x==0;
   - right with x==GRID_W-1;
   - up with y==0;
   - down with y==GRID_H-1;
   - x ≥ GRID_W or y ≥ GRID_H.
3. Otherwise assert mem_rd_req for exactly 1 cycle with the latched address, then go to MEM_WAIT.

State MEM_WAIT:
- Hold until mem_rd_valid. Latency is unbounded; no timeout.

State DECIDE (priority order):
1. Lowest-index unconsumed bonus tile matching → set its consumed bit; pulse score_plus; tile_idx=index; legal.
2. Else lowest-index unconsumed penalty tile matching → same, with score_minus.
3. Else cell==OCCUPIED → REJECT.
4. Else cell==END → WON.
5. Else → ACCEPT.

Consumed tiles:
- A consumed tile behaves as a plain cell (memory code decides).

Result states:
- ACCEPT/REJECT: done_check=1 for one cycle, is_legal=1 (ACCEPT) or 0 (REJECT), then IDLE.
- WON: done_check=1 and is_legal=1 for one cycle; game_won=1 held.
- GAME_OVER: done_check=1 and is_legal=0 for one cycle; game_over=1 held.
- WON and GAME_OVER stay until new_game.

Worst-case latency:
- check_req to done_check is 4 cycles plus memory wait (IDLE→CHECK→MEM_WAIT→DECIDE→result).
- Reject paths from CHECK take 2 cycles.

new_game:
- Wins over every other event in any state.
- Next cycle: IDLE, masks cleared, game_won=game_over=0.

resetn:
- Asserted mid-transaction, it aborts immediately.
- No pulse or mem_rd_req follows release.

Decomposition:
- Shared package maze_pkg holds:
  - cell-code constants;
  - FSM state enum;
  - move-direction bit positions.
- One sub-module, tile_match (params N, COORD_W):
  - inputs: packed coordinate list, consumed mask, x, y;
  - outputs: hit and lowest-index one-hot/encoded index;
  - purely combinational, instantiated twice (bonus, penalty).

Test Plan:
- Left-edge reject: x=0, move_dir=left, check_req → done_check after 2 cycles, is_legal=0, mem_rd_req never asserted.
- Memory wait: x=5, y=7, mem_rd_valid delayed 6 cycles with data=AVAILABLE → exactly one mem_rd_req at (5,7); done_check 1 cycle after DECIDE; is_legal=1.
- Bonus once only:
  - bonus 2 at (3,4), data=AVAILABLE → first visit gives score_plus=1, tile_idx=2;
  - second visit → score_plus=0, is_legal=1.
- Bonus and penalty overlap: both at (9,9), data=OCCUPIED → score_plus=1, is_legal=1; a repeat visit → score_minus=1.
- Win, then new_game:
  - data=END → game_won held high across 20 further check_req pulses, no further done_check;
  - new_game → game_won=0, state IDLE, masks cleared.
- Abort priority and async reset:
  - no_more_time=1 at a boundary → GAME_OVER, not REJECT;
  - resetn low during MEM_WAIT → all outputs 0 asynchronously.
